burst_sequence_checker: RTL
===========================

# burst_sequence_checker

Receive-side companion of the multi-channel one-shot burst generator: watches WIDTH pulse lines, checks that each fires exactly once and strictly in order from in[0] to in[WIDTH-1], and measures the cycle interval preceding each pulse. Results are returned on a packed step-width bus in the same layout the generator consumes, so a bench or on-chip self-test can loop generator output back and compare programmed widths against measured ones. Sits beside the generator in trigger/sequencing fabrics and in loopback test harnesses.

## Interface
- WIDTH, 8, number of monitored channels (>= 1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- arm  in  1  start one capture; accepted only while busy=0
- timeout  in  32  max allowed interval in cycles between expected pulses; 0 disables timeout
- in  in  WIDTH  pulse inputs; in[k] high for one or more cycles = event on channel k (every high cycle counts as an event)
- busy  out  1  capture in progress
- done  out  1  one-cycle strobe: full sequence captured without fault
- err  out  1  fault latched; held until next accepted arm or rst
- err_code  out  2  0 none, 1 wrong channel, 2 multiple channels same cycle, 3 timeout
- step_wdths  out  WIDTH*32  measured intervals; slot k = bits [k*32+31 : k*32]

## Operation
- States: IDLE, RUN. Internal: idx (expected channel, clog2 width, min 1 bit), cnt (32-bit interval counter).
- IDLE: in ignored. arm=1 -> RUN, busy<=1, idx<=0, cnt<=1, all step_wdths slots<=0, err<=0, err_code<=0.
- RUN, per cycle, evaluated in priority order:
  - popcount(in) >= 2 -> fault code 2.
  - in one-hot, bit != idx -> fault code 1.
  - in == onehot(idx) -> slot[idx]<=cnt, cnt<=1; if idx==WIDTH-1: done<=1, busy<=0, -> IDLE; else idx<=idx+1.
  - in == 0, timeout!=0 and cnt==timeout -> fault code 3.
  - in == 0 otherwise -> cnt<=cnt+1, saturating at 32'hFFFF_FFFF.
- Fault: err<=1, err_code<=code, busy<=0, -> IDLE; slots already captured keep values, unfilled slots stay 0.
- Interval definition: cnt equals j in the cycle j cycles after the arm-accept cycle or the previous accepted pulse. Pulse 1 cycle after arm -> slot0=1. A pulse in the same cycle cnt==timeout is accepted (no fault).
- A level held high on the just-accepted channel is seen next cycle as a wrong-channel event (code 1); inputs must be single-cycle pulses, matching generator output.
- arm while busy=1: ignored. arm in the same cycle as in activity while IDLE: in ignored that cycle.
- rst mid-run aborts immediately; no done, no err.

## Timing
- Reset values: busy=0, done=0, err=0, err_code=0, step_wdths=0, idx=0, cnt=0, state IDLE.
- All outputs registered. Pulse sampled at cycle t -> slot update, done, busy fall visible at t+1.
- arm sampled at t -> busy=1 and cleared slots/err at t+1; earliest accepted pulse at t+1.
- Timeout fault detected in cycle where cnt==timeout with in==0 -> err at next cycle (interval timeout+1 cycles after last event).
- done is exactly one cycle; new arm accepted in the same cycle done is high (busy already 0).
- WIDTH=1: first correct pulse sets done.

## Test plan
- WIDTH=8, timeout=0: arm at cycle 0, in[0..7] pulses at cycles 1,3,6,10,15,21,28,36 -> slots 1,2,3,4,5,6,7,8; done=1 only at cycle 37; busy 1 from cycle 1 through 36; err=0.
- Order fault: arm at 0, in[0] at 2, in[2] at 5 -> at cycle 6 err=1, err_code=1, busy=0, slot0=2, slots1..7=0, no done.
- Simultaneous: arm, in[0] at 1, in=8'b0000_0110 at 4 -> err_code=2, slot0=1, slot1=0.
- Timeout=5: arm at 0, in[0] at 1, nothing after -> err=1, err_code=3 at cycle 7; repeat with in[1] at cycle 6 -> accepted, slot1=5, no fault.
- rst asserted at cycle 10 of a run -> cycle 11 all outputs at reset values; arm pulsed while busy mid-run -> no change to idx, cnt or slots.
- Re-arm after fault: arm following case 2 -> err/err_code clear, slots zero next cycle, clean sequence then completes with done.

Source files
------------

// File: rtl/burst_sequence_checker_if.sv
// Interface bundle for burst_sequence_checker.
// Groups the capture control, pulse inputs and measurement results.
//   arm        : start one capture (driven by master)
//   timeout    : max cycles allowed between expected pulses, 0 disables (master)
//   in         : WIDTH pulse lines being monitored (master)
//   busy       : capture in progress (slave)
//   done       : one-cycle strobe on clean completion (slave)
//   err        : latched fault flag (slave)
//   err_code   : 0 none, 1 wrong channel, 2 multiple channels, 3 timeout (slave)
//   step_wdths : measured intervals, slot k at bits [k*32+31:k*32] (slave)
interface burst_sequence_checker_if #(
    parameter int WIDTH = 8
);
    logic                  arm;
    logic [31:0]           timeout;
    logic [WIDTH-1:0]      in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [1:0]            err_code;
    logic [WIDTH*32-1:0]   step_wdths;

    modport master (
        output arm, timeout, in,
        input  busy, done, err, err_code, step_wdths
    );

    modport slave (
        input  arm, timeout, in,
        output busy, done, err, err_code, step_wdths
    );
endinterface

// File: rtl/burst_sequence_checker.sv
// burst_sequence_checker
// Watches WIDTH pulse lines and checks that each fires exactly once, strictly
// in order from in[0] to in[WIDTH-1], measuring the cycle interval before each
// pulse. Intervals come back packed in the same layout the burst generator
// consumes, so generator output can be looped back and compared directly.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : burst_sequence_checker_if.slave (arm, timeout, in -> busy, done,
//         err, err_code, step_wdths)
module burst_sequence_checker #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    burst_sequence_checker_if.slave     bus
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [31:0]      cnt;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic [31:0]      slot_q [WIDTH];

    logic [WIDTH-1:0] expected;
    logic             hit;
    logic             fault;
    logic [1:0]       fault_code;

    // Classify this cycle's input activity against the expected channel.
    // Priority: multi-channel, then wrong single channel, then the expected
    // pulse, then a timeout on an idle cycle.
    always_comb begin
        expected   = WIDTH'(1) << idx;
        hit        = 1'b0;
        fault      = 1'b0;
        fault_code = 2'd0;
        if ($countones(bus.in) >= 2) begin
            fault      = 1'b1;
            fault_code = 2'd2;
        end else if (bus.in != '0 && bus.in != expected) begin
            fault      = 1'b1;
            fault_code = 2'd1;
        end else if (bus.in == expected) begin
            hit = 1'b1;
        end else if (bus.timeout != 32'd0 && cnt == bus.timeout) begin
            fault      = 1'b1;
            fault_code = 2'd3;
        end
    end

    // Capture FSM. cnt starts at 1 on arm/accepted pulse so that it equals
    // the number of cycles elapsed since that event when the next pulse
    // arrives. done is a one-cycle strobe, so it defaults low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            for (int k = 0; k < WIDTH; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.arm) begin
                        state      <= RUN;
                        busy_q     <= 1'b1;
                        idx        <= '0;
                        cnt        <= 32'd1;
                        err_q      <= 1'b0;
                        err_code_q <= 2'd0;
                        for (int k = 0; k < WIDTH; k++) begin
                            slot_q[k] <= '0;
                        end
                    end
                end
                RUN: begin
                    if (fault) begin
                        err_q      <= 1'b1;
                        err_code_q <= fault_code;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                    end else if (hit) begin
                        slot_q[idx] <= cnt;
                        cnt         <= 32'd1;
                        if (idx == LAST_IDX) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (cnt != 32'hFFFF_FFFF) begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Pack the per-channel slots into the generator's step-width layout.
    for (genvar g = 0; g < WIDTH; g++) begin : g_pack
        assign bus.step_wdths[g*32 +: 32] = slot_q[g];
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;

endmodule
